fetch_sequencer: RTL and testbench

- Multi-cycle instruction sequencer in front of the `main` CPU datapath.
- Owns the PC and fetches instruction words from instruction memory over a req/ack handshake.
- Presents each instruction stably to `main.inst` for a fixed 4-phase sequence: DECODE, EXECUTE, WRITEBACK, then the next FETCH.
- Applies jump/branch redirects reported by the datapath in EXECUTE.

---
 rtl/fetch_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches instruction words over a req/ack
// handshake, holds each word stable through DECODE/EXECUTE/WRITEBACK and
// applies jump/branch redirects that the datapath reports in EXECUTE.
// Build option: define FETCH_TIMEOUT_EN to fault a fetch whose ack has not
// arrived after TIMEOUT request cycles. Without it, FETCH waits indefinitely.
//
// state     | meaning
// FETCH     | imem_req/imem_addr held until imem_ack, word captured into inst
// DECODE    | inst valid, datapath decodes (stall holds)
// EXECUTE   | datapath executes, redirect sampled on the leaving edge
// WRITEBACK | results written, leaving edge retires and loads pc from next_pc
// FAULT     | misaligned redirect or fetch timeout, left only by reset
module fetch_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ack,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  output logic [1:0]      phase,
  output logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fault,
  output logic            retired
);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            inst_valid_q, inst_valid_d;
  logic            imem_req_q, imem_req_d;
  logic            fault_q, fault_d;
  logic            retired_q, retired_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
`endif

  // State and datapath registers, cleared asynchronously to reset values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      next_pc_q    <= RESET_PC + XLEN'(4);
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
      fault_q      <= 1'b0;
      retired_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      next_pc_q    <= next_pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      imem_req_q   <= imem_req_d;
      fault_q      <= fault_d;
      retired_q    <= retired_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Fetch wait counter: counts request cycles that saw no ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Next-state and register updates for the fetch/decode/execute/writeback walk.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    next_pc_d    = next_pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    imem_req_d   = imem_req_q;
    fault_d      = fault_q;
    retired_d    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d        = cnt_q;
    cnt_inc      = cnt_q + CNT_W'(1);
`endif

    case (state_q)
      ST_FETCH: begin
        // An ack only counts while our request is actually out.
        if (imem_req_q && imem_ack) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          imem_req_d   = 1'b0;
          state_d      = ST_DECODE;
`ifdef FETCH_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end else begin
          imem_req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          if (imem_req_q) begin
            if (cnt_inc == CNT_W'(TIMEOUT)) begin
              imem_req_d = 1'b0;
              fault_d    = 1'b1;
              cnt_d      = '0;
              state_d    = ST_FAULT;
            end else begin
              cnt_d = cnt_inc;
            end
          end
`endif
        end
      end
      ST_DECODE: begin
        if (!stall) begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        // Redirect is re-sampled every stalled cycle; only the leaving edge counts.
        if (!stall) begin
          if (redirect_valid) begin
            if (redirect_pc[1:0] != 2'b00) begin
              fault_d      = 1'b1;
              inst_valid_d = 1'b0;
              state_d      = ST_FAULT;
            end else begin
              next_pc_d = redirect_pc;
              state_d   = ST_WRITEBACK;
            end
          end else begin
            next_pc_d = pc_q + XLEN'(4);
            state_d   = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: begin
        // Request goes out with the new pc in the very first FETCH cycle.
        if (!stall) begin
          retired_d    = 1'b1;
          pc_d         = next_pc_q;
          inst_valid_d = 1'b0;
          imem_req_d   = 1'b1;
          state_d      = ST_FETCH;
        end
      end
      ST_FAULT: begin
        imem_req_d   = 1'b0;
        inst_valid_d = 1'b0;
        fault_d      = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Phase encoding seen by the datapath; FAULT reads as phase 0.
  always_comb begin
    phase = 2'd0;
    case (state_q)
      ST_DECODE:    phase = 2'd1;
      ST_EXECUTE:   phase = 2'd2;
      ST_WRITEBACK: phase = 2'd3;
      default:      phase = 2'd0;
    endcase
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign fault      = fault_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: an instruction-memory model driven from the main
// sequence, with scoreboard queues of expected fetch addresses and captured
// instruction words that a negedge monitor pops as the DUT produces them.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] inst;
  logic        inst_valid;
  logic [1:0]  phase;
  logic [31:0] pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic        retired;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_fetch_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] model_pc;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ack       (imem_ack),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .phase          (phase),
    .pc             (pc),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .retired        (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: each new request and each newly valid instruction
  // must match the head of its queue.
  initial begin
    logic req_prev;
    logic val_prev;
    req_prev = 1'b0;
    val_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_req && !req_prev) begin
        chk("sb_fetch_pending", 32'(exp_fetch_q.size() != 0), 32'd1);
        if (exp_fetch_q.size() != 0) chk("sb_fetch_addr", imem_addr, exp_fetch_q.pop_front());
      end
      if (inst_valid && !val_prev) begin
        chk("sb_inst_pending", 32'(exp_inst_q.size() != 0), 32'd1);
        if (exp_inst_q.size() != 0) chk("sb_inst_word", inst, exp_inst_q.pop_front());
      end
      req_prev = imem_req;
      val_prev = inst_valid;
    end
  end

  // Memory model: wait for a request, hold ack off for lat cycles (with stall
  // asserted to show FETCH ignores it), then return data.
  task automatic fetch_word(input logic [31:0] data, input int lat);
    logic [31:0] a0;
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("fetch_req_wait", 32'(imem_req), 32'd1);
    a0 = imem_addr;
    chk("fetch_addr", a0, model_pc);
    stall = (lat > 0);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, a0);
      chk("wait_phase", 32'(phase), 32'd0);
    end
    imem_rdata = data;
    imem_ack   = 1'b1;
    exp_inst_q.push_back(data);
    tick();
    imem_ack   = 1'b0;
    stall      = 1'b0;
    imem_rdata = $urandom;
  endtask

  // One full instruction: fetch, decode (optionally with a stray redirect),
  // execute (optionally stalled with a changing redirect), writeback.
  task automatic run_insn(input logic [31:0] data, input int lat, input logic dec_redir,
                          input logic redir, input logic [31:0] rpc, input int stall_n,
                          input logic [31:0] exp_next);
    exp_fetch_q.push_back(exp_next);
    fetch_word(data, lat);
    chk("dec_phase", 32'(phase), 32'd1);
    chk("dec_valid", 32'(inst_valid), 32'd1);
    chk("dec_req", 32'(imem_req), 32'd0);
    if (dec_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0500;
    end
    tick();
    redirect_valid = 1'b0;
    chk("exe_phase", 32'(phase), 32'd2);
    if (stall_n > 0) begin
      stall          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      repeat (stall_n) begin
        tick();
        chk("stall_phase", 32'(phase), 32'd2);
        chk("stall_inst", inst, data);
      end
      stall = 1'b0;
    end
    redirect_valid = redir;
    redirect_pc    = rpc;
    tick();
    redirect_valid = 1'b0;
    chk("wb_phase", 32'(phase), 32'd3);
    chk("wb_inst", inst, data);
    chk("wb_pc", pc, model_pc);
    chk("wb_retired", 32'(retired), 32'd0);
    tick();
    chk("ret_pulse", 32'(retired), 32'd1);
    chk("ret_pc", pc, exp_next);
    chk("ret_req", 32'(imem_req), 32'd1);
    chk("ret_phase", 32'(phase), 32'd0);
    chk("ret_valid", 32'(inst_valid), 32'd0);
    model_pc = exp_next;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    model_pc       = 32'h0;
    repeat (3) tick();

    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_pc", pc, 32'h0);

    exp_fetch_q.push_back(32'h0);
    rst = 1'b1;
    chk("cyc0_req", 32'(imem_req), 32'd0);
    tick();
    chk("cyc1_req", 32'(imem_req), 32'd1);
    chk("cyc1_addr", imem_addr, 32'h0);

    run_insn(32'h1234_A0B7, 0, 1'b0, 1'b0, 32'h0, 0, 32'h0000_0004);
    tick();
    chk("ret_drop", 32'(retired), 32'd0);
    chk("hold_addr", imem_addr, 32'h0000_0004);

    run_insn(32'h0000_0013, 0, 1'b0, 1'b0, 32'h0,         0, 32'h0000_0008);
    run_insn(32'h0000_006F, 0, 1'b0, 1'b1, 32'h0000_0808, 0, 32'h0000_0808);
    run_insn(32'h0000_0063, 0, 1'b1, 1'b0, 32'h0,         0, 32'h0000_080C);
    run_insn(32'hDEAD_BEEF, 0, 1'b0, 1'b1, 32'h0000_0200, 3, 32'h0000_0200);
    run_insn(32'h0040_0093, 3, 1'b0, 1'b1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
    run_insn(32'h0010_0113, 14, 1'b0, 1'b0, 32'h0,        0, 32'h0000_0000);
    chk("ack_at_limit_fault", 32'(fault), 32'd0);
    run_insn(32'h0400_006F, 0, 1'b0, 1'b1, 32'h0000_0040, 0, 32'h0000_0040);

    repeat (4) tick();
    chk("midfetch_req", 32'(imem_req), 32'd1);
    chk("midfetch_addr", imem_addr, 32'h0000_0040);
    rst = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    repeat (2) tick();
    model_pc = 32'h0;
    exp_fetch_q.push_back(32'h0);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    chk("stray_phase", 32'(phase), 32'd0);
    chk("stray_valid", 32'(inst_valid), 32'd0);
    chk("stray_inst", inst, 32'h0);
    chk("stray_req", 32'(imem_req), 32'd1);

    fetch_word(32'h0000_00EF, 0);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_phase", 32'(phase), 32'd0);
    chk("mis_req", 32'(imem_req), 32'd0);
    chk("mis_valid", 32'(inst_valid), 32'd0);
    chk("mis_pc", pc, 32'h0);
    imem_ack = 1'b1;
    repeat (3) tick();
    imem_ack = 1'b0;
    chk("flt_hold_fault", 32'(fault), 32'd1);
    chk("flt_hold_req", 32'(imem_req), 32'd0);
    chk("flt_hold_retired", 32'(retired), 32'd0);
    rst = 1'b0;
    #1;
    chk("flt_clear", 32'(fault), 32'd0);
    repeat (2) tick();

    exp_fetch_q.push_back(32'h0);
    rst = 1'b1;
    tick();
    chk("to_req", 32'(imem_req), 32'd1);
`ifdef FETCH_TIMEOUT_EN
    repeat (14) tick();
    chk("to_before_fault", 32'(fault), 32'd0);
    chk("to_before_req", 32'(imem_req), 32'd1);
    tick();
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_req_drop", 32'(imem_req), 32'd0);
    chk("to_pc", pc, 32'h0);
    chk("to_phase", 32'(phase), 32'd0);
`else
    repeat (30) tick();
    chk("nto_fault", 32'(fault), 32'd0);
    chk("nto_req", 32'(imem_req), 32'd1);
    chk("nto_addr", imem_addr, 32'h0);
`endif

    tick();
    chk("sb_fetch_left", 32'(exp_fetch_q.size()), 32'd0);
    chk("sb_inst_left", 32'(exp_inst_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
